// File: rtl/calc_bcd_display.sv
// Result display stage: accepts an 8-bit value, converts it to BCD by sequential double-dabble,
// and scans it onto a 4-digit active-low 7-segment display. Define CALC_BCD_SIGNED_EN for two's-complement input.
module calc_bcd_display #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [11:0] bcd,
  output logic        bcd_neg,
  output logic        bcd_valid,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  bin_reg, bin_next;
  logic [11:0] scratch_reg, scratch_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        sign_reg, sign_next;
  logic [11:0] bcd_reg, bcd_next;
  logic        bcd_neg_reg, bcd_neg_next;
  logic        bcd_valid_reg, bcd_valid_next;
  logic [15:0] scan_reg;
  logic [1:0]  idx_reg;
  logic [3:0]  an_reg, an_next;
  logic [6:0]  seg_reg, seg_next;
  logic [11:0] adj;
  logic [7:0]  in_mag;
  logic        in_sign;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

`ifdef CALC_BCD_SIGNED_EN
  // Two's-complement negate; 8'h80 maps to 128, which still fits the 8-bit magnitude.
  assign in_sign = in_data[7];
  assign in_mag  = in_data[7] ? (8'd0 - in_data) : in_data;
`else
  assign in_sign = 1'b0;
  assign in_mag  = in_data;
`endif

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                              scratch_reg[gi*4 +: 4] + 4'd3 : scratch_reg[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    bin_next       = bin_reg;
    scratch_next   = scratch_reg;
    cnt_next       = cnt_reg;
    sign_next      = sign_reg;
    bcd_next       = bcd_reg;
    bcd_neg_next   = bcd_neg_reg;
    bcd_valid_next = 1'b0;
    in_ready       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bin_next     = in_mag;
          scratch_next = 12'h000;
          cnt_next     = 3'd0;
          sign_next    = in_sign;
          state_next   = CONV;
        end
      end
      CONV: begin
        scratch_next = {adj[10:0], bin_reg[7]};
        bin_next     = {bin_reg[6:0], 1'b0};
        cnt_next     = cnt_reg + 3'd1;
        if (cnt_reg == 3'd7) begin
          bcd_next       = {adj[10:0], bin_reg[7]};
          bcd_neg_next   = sign_reg;
          bcd_valid_next = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Digit content is derived from the registered result, so it only changes on completion.
  always_comb begin
    an_next  = ~(4'b0001 << idx_reg);
    seg_next = SEG_BLANK;
    case (idx_reg)
      2'd0: seg_next = seg7(bcd_reg[3:0]);
      2'd1: if (bcd_reg[11:4] != 8'h00) seg_next = seg7(bcd_reg[7:4]);
      2'd2: if (bcd_reg[11:8] != 4'h0) seg_next = seg7(bcd_reg[11:8]);
      default: if (bcd_neg_reg) seg_next = SEG_DASH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bin_reg       <= 8'h00;
      scratch_reg   <= 12'h000;
      cnt_reg       <= 3'd0;
      sign_reg      <= 1'b0;
      bcd_reg       <= 12'h000;
      bcd_neg_reg   <= 1'b0;
      bcd_valid_reg <= 1'b0;
      scan_reg      <= 16'd0;
      idx_reg       <= 2'd0;
      an_reg        <= 4'b1110;
      seg_reg       <= 7'b1000000;
    end else begin
      state_reg     <= state_next;
      bin_reg       <= bin_next;
      scratch_reg   <= scratch_next;
      cnt_reg       <= cnt_next;
      sign_reg      <= sign_next;
      bcd_reg       <= bcd_next;
      bcd_neg_reg   <= bcd_neg_next;
      bcd_valid_reg <= bcd_valid_next;
      an_reg        <= an_next;
      seg_reg       <= seg_next;
      if (scan_reg == SCAN_DIV - 16'd1) begin
        scan_reg <= 16'd0;
        idx_reg  <= idx_reg + 2'd1;
      end else begin
        scan_reg <= scan_reg + 16'd1;
      end
    end
  end

  assign bcd       = bcd_reg;
  assign bcd_neg   = bcd_neg_reg;
  assign bcd_valid = bcd_valid_reg;
  assign an        = an_reg;
  assign seg       = seg_reg;
  assign dp        = 1'b1;

endmodule

// File: tb/tb_calc_bcd_display.sv
// Randomized self-checking bench for calc_bcd_display against a decimal-arithmetic reference model.
module tb_calc_bcd_display;
  localparam logic [15:0] SD = 16'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [11:0] bcd;
  logic        bcd_neg;
  logic        bcd_valid;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int errors = 0;
  int checks = 0;
  int k_cyc;
  int model_mag = 0;
  bit model_neg = 1'b0;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  calc_bcd_display #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bcd(bcd), .bcd_neg(bcd_neg), .bcd_valid(bcd_valid), .an(an), .seg(seg), .dp(dp)
  );

  // Count of non-reset rising edges since the last reset edge: drives the scan model.
  always @(posedge clk) begin
    if (rst) k_cyc <= 0;
    else     k_cyc <= k_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mag_of(input logic [7:0] v);
`ifdef CALC_BCD_SIGNED_EN
    return v[7] ? 256 - int'(v) : int'(v);
`else
    return int'(v);
`endif
  endfunction

  function automatic bit neg_of(input logic [7:0] v);
`ifdef CALC_BCD_SIGNED_EN
    return v[7];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] bcd_of(input int m);
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int idx);
    case (idx)
      0: return seg_tab[model_mag % 10];
      1: return (model_mag >= 10) ? seg_tab[(model_mag / 10) % 10] : 7'b1111111;
      2: return (model_mag >= 100) ? seg_tab[model_mag / 100] : 7'b1111111;
      default: return model_neg ? 7'b0111111 : 7'b1111111;
    endcase
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic convert(input logic [7:0] v);
    wait_ready();
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      check("busy", 32'(in_ready), 32'd0);
      check("early_valid", 32'(bcd_valid), 32'd0);
      @(negedge clk);
    end
    model_mag = mag_of(v);
    model_neg = neg_of(v);
    check("valid_pulse", 32'(bcd_valid), 32'd1);
    check("ready_back", 32'(in_ready), 32'd1);
    check("bcd", 32'(bcd), 32'(bcd_of(model_mag)));
    check("bcd_neg", 32'(bcd_neg), 32'(model_neg));
    $display("convert in=%02h -> bcd=%03h neg=%0b", v, bcd, bcd_neg);
    @(negedge clk);
    check("valid_single", 32'(bcd_valid), 32'd0);
  endtask

  task automatic show(input int n);
    int idx;
    logic [3:0] exp_an;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idx = (k_cyc == 0) ? 0 : ((k_cyc - 1) / int'(SD)) % 4;
      exp_an = ~(4'b0001 << idx);
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg(idx)));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hE);
    check("rst_seg", 32'(seg), 32'h40);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(bcd_valid), 32'd0);
    check("rst_dp", 32'(dp), 32'd1);
    rst = 1'b0;
    show(1);
    $display("reset released");

    convert(8'd255);
    convert(8'd107);
    show(16);
    convert(8'd5);
    show(16);
    convert(8'd0);
    show(16);

    // Hold in_valid with 9 during a conversion of 200: 9 must wait for in_ready.
    wait_ready();
    in_valid = 1'b1;
    in_data = 8'd200;
    @(negedge clk);
    in_data = 8'd9;
    for (int i = 0; i < 8; i++) begin
      check("hold_busy", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    check("hold_valid1", 32'(bcd_valid), 32'd1);
    check("hold_bcd1", 32'(bcd), 32'h200);
    @(negedge clk);
    check("hold_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("hold_early", 32'(bcd_valid), 32'd0);
    @(negedge clk);
    check("hold_valid2", 32'(bcd_valid), 32'd1);
    check("hold_bcd2", 32'(bcd), 32'h009);
    model_mag = 9;
    model_neg = 1'b0;
    $display("hold test: 200 then 9 -> bcd=%03h", bcd);
    show(8);

    // Reset in the middle of converting 99.
    wait_ready();
    in_valid = 1'b1;
    in_data = 8'd99;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_mag = 0;
    model_neg = 1'b0;
    check("abort_valid", 32'(bcd_valid), 32'd0);
    check("abort_bcd", 32'(bcd), 32'h0);
    check("abort_neg", 32'(bcd_neg), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_an", 32'(an), 32'hE);
    check("abort_seg", 32'(seg), 32'h40);
    for (int i = 0; i < 12; i++) begin
      check("abort_no_valid", 32'(bcd_valid), 32'd0);
      check("abort_bcd_hold", 32'(bcd), 32'h0);
      @(negedge clk);
    end
    $display("abort test: bcd=%03h", bcd);
    show(16);

`ifdef CALC_BCD_SIGNED_EN
    convert(8'hF6);
    show(16);
    convert(8'h80);
    show(16);
`endif

    for (int t = 0; t < 20; t++) begin
      convert(8'($urandom_range(0, 255)));
      show(6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
